// File: rtl/barrel_shift_arbiter_if.sv
// barrel_shift_arbiter_if: two requester valid/ready channels and one id-tagged result channel.
interface barrel_shift_arbiter_if;
   logic       a_valid, a_ready, a_left;
   logic [7:0] a_d;
   logic [2:0] a_c;
   logic       b_valid, b_ready, b_left;
   logic [7:0] b_d;
   logic [2:0] b_c;
   logic       r_valid, r_ready, r_id;
   logic [7:0] r_q;
   modport master (
      output a_valid, a_d, a_c, a_left, b_valid, b_d, b_c, b_left, r_ready,
      input  a_ready, b_ready, r_valid, r_q, r_id
   );
   modport slave (
      input  a_valid, a_d, a_c, a_left, b_valid, b_d, b_c, b_left, r_ready,
      output a_ready, b_ready, r_valid, r_q, r_id
   );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one 8-bit rotate-right datapath between two requesters,
// with a single registered, id-tagged result slot.
module barrel_shift_arbiter #(
   parameter bit PRIO_INIT = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   barrel_shift_arbiter_if.slave bus
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t     state, state_nxt;
   logic       prio, slot_free, any, gnt, accept, left;
   logic [7:0] d, q;
   logic [2:0] c, amt;
   always_comb begin
      any       = bus.a_valid | bus.b_valid;
      gnt       = (bus.a_valid & bus.b_valid) ? prio : bus.b_valid;
      slot_free = (state == EMPTY) | bus.r_ready;
      accept    = rst_n & slot_free & any;
      bus.a_ready = accept & ~gnt;
      bus.b_ready = accept & gnt;
      d    = gnt ? bus.b_d : bus.a_d;
      c    = gnt ? bus.b_c : bus.a_c;
      left = gnt ? bus.b_left : bus.a_left;
      amt  = left ? 3'd0 - c : c;
   end
   // Left rotation by c is the right rotation by -c mod 8, so one mux column per bit suffices.
   for (genvar i = 0; i < 8; i++) begin : gen_rot
      assign q[i] = d[3'(i) + amt];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else state <= state_nxt;
   always_comb
      state_nxt = accept ? FULL : (bus.r_ready ? EMPTY : state);
   always_comb
      bus.r_valid = (state == FULL);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.r_q  <= 8'h00;
         bus.r_id <= 1'b0;
         prio     <= PRIO_INIT;
      end else if (accept) begin
         bus.r_q  <= q;
         bus.r_id <= gnt;
         prio     <= ~gnt;
      end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed vectors, arbitration/backpressure/reset sequences, full sweep and
// randomized traffic checked against a queue-based reference model.
module tb_barrel_shift_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0, errors = 0, hs = 0;
   always #5 clk = ~clk;

   barrel_shift_arbiter_if bus();
   barrel_shift_arbiter #(.PRIO_INIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always @(posedge clk) if (rst_n && bus.r_valid && bus.r_ready) hs <= hs + 1;

   typedef struct {
      logic [7:0] d;
      logic [2:0] c;
      logic       left;
      logic [7:0] q;
   } vec_t;

   function automatic logic [7:0] rot(logic [7:0] d, logic [2:0] c, logic left);
      logic [15:0] w;
      w = {d, d};
      w = left ? w << c : w >> c;
      return left ? w[15:8] : w[7:0];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t       tbl[6];
   logic [8:0] exp_q[$];
   logic [8:0] res;
   logic       free, win, acc;

   initial begin
      tbl[0] = '{8'h81, 3'd1, 1'b0, 8'hC0};
      tbl[1] = '{8'h01, 3'd3, 1'b1, 8'h08};
      tbl[2] = '{8'h01, 3'd0, 1'b1, 8'h01};
      tbl[3] = '{8'h0F, 3'd4, 1'b0, 8'hF0};
      tbl[4] = '{8'h80, 3'd7, 1'b1, 8'h40};
      tbl[5] = '{8'hA5, 3'd0, 1'b0, 8'hA5};

      rst_n = 1'b0;
      bus.a_valid = 1'b1; bus.a_d = 8'h00; bus.a_c = 3'd0; bus.a_left = 1'b0;
      bus.b_valid = 1'b1; bus.b_d = 8'h00; bus.b_c = 3'd0; bus.b_left = 1'b0;
      bus.r_ready = 1'b1;
      repeat (2) tick();
      chk("rst_r_valid", bus.r_valid, 0);
      chk("rst_r_q", bus.r_q, 0);
      chk("rst_r_id", bus.r_id, 0);
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         bus.a_valid = 1'b1; bus.a_d = tbl[i].d; bus.a_c = tbl[i].c; bus.a_left = tbl[i].left;
         #1;
         chk("tbl_a_ready", bus.a_ready, 1);
         chk("tbl_b_ready", bus.b_ready, 0);
         tick();
         chk("tbl_r_valid", bus.r_valid, 1);
         chk("tbl_r_q", bus.r_q, tbl[i].q);
         chk("tbl_r_id", bus.r_id, 0);
      end

      bus.a_valid = 1'b0; bus.r_ready = 1'b0;
      tick();
      chk("hold_r_valid", bus.r_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_r_valid", bus.r_valid, 0);
      chk("async_r_q", bus.r_q, 0);
      chk("async_r_id", bus.r_id, 0);
      tick();
      rst_n = 1'b1;

      bus.a_valid = 1'b1; bus.a_d = 8'h0F; bus.a_c = 3'd4; bus.a_left = 1'b0;
      bus.b_valid = 1'b1; bus.b_d = 8'hF0; bus.b_c = 3'd4; bus.b_left = 1'b0;
      bus.r_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_a_ready", bus.a_ready, (k % 2) == 0);
         chk("fair_b_ready", bus.b_ready, (k % 2) == 1);
         tick();
         chk("fair_r_valid", bus.r_valid, 1);
         chk("fair_r_id", bus.r_id, k % 2);
         chk("fair_r_q", bus.r_q, (k % 2) ? 8'h0F : 8'hF0);
      end

      bus.r_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_a_ready", bus.a_ready, 0);
         chk("bp_b_ready", bus.b_ready, 0);
         tick();
         chk("bp_r_valid", bus.r_valid, 1);
         chk("bp_r_id", bus.r_id, 1);
         chk("bp_r_q", bus.r_q, 8'h0F);
      end
      bus.r_ready = 1'b1;
      #1;
      chk("rel_a_ready", bus.a_ready, 1);
      chk("rel_b_ready", bus.b_ready, 0);
      tick();
      chk("rel_r_id", bus.r_id, 0);
      chk("rel_r_q", bus.r_q, 8'hF0);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      tick();
      chk("drain_r_valid", bus.r_valid, 0);

      begin
         int hs0;
         hs0 = hs;
         for (int id = 0; id < 2; id++)
            for (int d = 0; d < 256; d++)
               for (int c = 0; c < 8; c++)
                  for (int l = 0; l < 2; l++) begin
                     bus.a_valid = (id == 0); bus.b_valid = (id == 1);
                     bus.a_d = 8'(d); bus.a_c = 3'(c); bus.a_left = 1'(l);
                     bus.b_d = 8'(d); bus.b_c = 3'(c); bus.b_left = 1'(l);
                     tick();
                     chk("sweep_id_q", {bus.r_valid, bus.r_id, bus.r_q},
                         {1'b1, 1'(id), rot(8'(d), 3'(c), 1'(l))});
                  end
         bus.a_valid = 1'b0; bus.b_valid = 1'b0;
         tick();
         chk("sweep_handshakes", hs - hs0, 8192);
      end

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      begin
         logic m_prio;
         m_prio = 1'b0;
         for (int n = 0; n < 3000; n++) begin
            if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
               bus.a_valid = 1'b1; bus.a_d = 8'($urandom); bus.a_c = 3'($urandom); bus.a_left = 1'($urandom);
            end
            if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
               bus.b_valid = 1'b1; bus.b_d = 8'($urandom); bus.b_c = 3'($urandom); bus.b_left = 1'($urandom);
            end
            bus.r_ready = ($urandom_range(0, 3) != 0);
            #1;
            free = (exp_q.size() == 0) || bus.r_ready;
            win  = (bus.a_valid && bus.b_valid) ? m_prio : bus.b_valid;
            acc  = free && (bus.a_valid || bus.b_valid);
            chk("rnd_a_ready", bus.a_ready, acc && !win);
            chk("rnd_b_ready", bus.b_ready, acc && win);
            chk("rnd_r_valid", bus.r_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("rnd_result", {bus.r_id, bus.r_q}, exp_q[0]);
            @(posedge clk);
            if (exp_q.size() != 0 && bus.r_ready) res = exp_q.pop_front();
            if (acc) begin
               exp_q.push_back(win ? {1'b1, rot(bus.b_d, bus.b_c, bus.b_left)}
                                   : {1'b0, rot(bus.a_d, bus.a_c, bus.a_left)});
               m_prio = ~win;
            end
            #1;
            if (acc && !win) bus.a_valid = 1'b0;
            if (acc && win) bus.b_valid = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/barrel_shift_arbiter.md
Name: barrel_shift_arbiter

Overview:
- Shares one 8-bit rotate datapath between two requesters, A and B.
- The datapath uses the existing per-bit mux structure: q[i] = d[(i+amt) mod 8], i.e. rotate right by amt.
- Each requester has a valid/ready handshake. Arbitration is round-robin.
- Results are registered and returned on a single valid/ready output channel, tagged with the requester id.
- Left rotation is converted to an equivalent right rotation before the shifter.

Parameters:
- PRIO_INIT, default 0: requester holding priority after reset (0 = A, 1 = B).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A presents a request.
- a_ready  output  1  A's request is accepted this cycle.
- a_d  input  8  A data word.
- a_c  input  3  A rotate amount.
- a_left  input  1  A direction: 1 = rotate left, 0 = rotate right.
- b_valid  input  1  requester B presents a request.
- b_ready  output  1  B's request is accepted this cycle.
- b_d  input  8  B data word.
- b_c  input  3  B rotate amount.
- b_left  input  1  B direction: 1 = rotate left, 0 = rotate right.
- r_valid  output  1  result register holds a valid result.
- r_ready  input  1  consumer accepts the result.
- r_q  output  8  rotated result.
- r_id  output  1  id of the requester that produced r_q (0 = A, 1 = B).

Behaviour:
- Reset (async, rst_n=0): r_valid=0, r_q=8'h00, r_id=0, prio=PRIO_INIT, state=EMPTY.
  - a_ready and b_ready are 0 while rst_n=0.
  - Reset mid-transfer discards any held result; no result is emitted for it.
- State machine (output register):
  - EMPTY: r_valid=0.
  - FULL: r_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on (r_ready and accept); the result is replaced.
  - FULL -> EMPTY on (r_ready and no accept).
  - FULL holds on !r_ready.
- slot_free = (state==EMPTY) or r_ready. This is combinational from r_ready, so throughput is 1 result per cycle.
- Grant (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester selected by prio wins.
  - Neither valid: no grant.
- x_ready = slot_free and grant==x. At most one of a_ready/b_ready is 1 in any cycle.
- Accept = (a_valid & a_ready) | (b_valid & b_ready).
- On accept:
  - prio <= id of the non-granted requester.
  - prio is unchanged when there is no accept, including while a request is stalled by backpressure.
- Amount rule:
  - amt = left ? (8 - c) mod 8 : c, computed as 3-bit two's-complement negate.
  - c=0 with left=1 gives amt=0.
- On accept, same edge:
  - r_q <= rotr(d_granted, amt).
  - r_id <= granted id.
  - Latency: 1 cycle from the accept edge to r_valid=1.
- While r_valid=1 and r_ready=0: r_q and r_id hold stable.
- Requesters hold d, c and left stable while valid=1 and ready=0. A request may not be withdrawn before acceptance.
- Fairness: with both requesters continuously valid and r_ready=1, grants alternate A,B,A,B… (starting per PRIO_INIT).
- The output is never dropped or overwritten unless it is consumed in the same cycle.

Test Plan:
- Reset with PRIO_INIT=0, then A only: a_d=8'h81, a_c=1, a_left=0 -> accepted in cycle 0; next cycle r_valid=1, r_q=8'hC0, r_id=0.
- A only, left rotate: a_d=8'h01, a_c=3, a_left=1 -> r_q=8'h08. With a_c=0, a_left=1 -> r_q=8'h01.
- Both valid every cycle, r_ready=1, PRIO_INIT=0, a_d=8'h0F/a_c=4 and b_d=8'hF0/b_c=4 -> r_id sequence 0,1,0,1, each r_q=8'hF0 (A) / 8'h0F (B), one result per cycle.
- r_ready=0 for 3 cycles after the first result while both valid -> a_ready=b_ready=0, r_q/r_id stable and prio unchanged. On release, exactly one new grant, to the requester opposite the last winner.
- Full sweep: all 256 d × 8 c × both directions through A, then through B -> r_q equals the reference rotate for each vector; no lost or duplicate results, counted by r_valid&r_ready.
- rst_n asserted asynchronously mid-cycle while FULL with r_ready=0 -> r_valid drops immediately, r_q=8'h00, and prio returns to PRIO_INIT after release.
